// File: rtl/node_reg_buffer_pkg.sv
// Shared helpers for the valid/ready pipeline node family: modulo pointer
// stepping and occupancy-counter sizing.
package node_pkg;

    // Per-cycle handshake events seen by a node.
    typedef struct packed {
        logic push;
        logic pop;
        logic flush;
    } node_ev_t;

    // Modulo-depth increment with an explicit wrap, so odd depths work.
    function automatic int unsigned wrap_inc(input int unsigned ptr,
                                             input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

    // Bits needed to represent an occupancy of 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/node_reg_buffer_wrap_ctr.sv
// Modulo-DEPTH pointer with increment and synchronous clear; clear wins.
module node_wrap_ctr
    import node_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (clr) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= PTR_W'(wrap_inc(32'(r_ptr), DEPTH));
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/node_reg_buffer.sv
// Valid/ready pipeline node with a DEPTH-entry circular buffer; every
// handshake output comes from flops, so no input reaches an output in one cycle.
module node_reg_buffer
    import node_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             up_valid_in,
    output logic             up_ready_out,
    output logic [WIDTH-1:0] data_out,
    output logic             dn_valid_out,
    input  logic             dn_ready_in,
    input  logic             flush_in,
    output logic [CNT_W-1:0] count_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             r_up_ready;
    logic [PTR_W-1:0] w_wr_ptr;
    logic [PTR_W-1:0] w_rd_ptr;
    logic             w_valid;
    node_ev_t         w_ev;

    assign w_valid = (r_count != '0);

    // A push concurrent with flush is dropped; the pop still completes downstream.
    always_comb begin
        w_ev       = '0;
        w_ev.flush = flush_in;
        w_ev.push  = up_valid_in & r_up_ready & ~flush_in;
        w_ev.pop   = w_valid & dn_ready_in;
    end

    always_comb begin
        w_count_next = r_count;
        if (w_ev.flush) begin
            w_count_next = '0;
        end else begin
            case ({w_ev.push, w_ev.pop})
                2'b10:   w_count_next = r_count + CNT_W'(1);
                2'b01:   w_count_next = r_count - CNT_W'(1);
                default: w_count_next = r_count;
            endcase
        end
    end

    // Ready looks at next occupancy only, never at the current dn_ready_in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_up_ready <= 1'b0;
        end else begin
            r_count    <= w_count_next;
            r_up_ready <= (w_count_next < CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_ev.push) begin
            r_mem[w_wr_ptr] <= data_in;
        end
    end

    node_wrap_ctr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_ev.push),
        .clr   (w_ev.flush),
        .ptr   (w_wr_ptr)
    );

    node_wrap_ctr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_ev.pop),
        .clr   (w_ev.flush),
        .ptr   (w_rd_ptr)
    );

    assign dn_valid_out = w_valid;
    assign data_out     = w_valid ? r_mem[w_rd_ptr] : '0;
    assign up_ready_out = r_up_ready;
    assign count_out    = r_count;

endmodule

// File: tb/tb_node_reg_buffer.sv
// Bench for node_reg_buffer at DEPTH 2, 4 and 3, checked against a queue model
// of the buffer plus a hand-derived vector table.
module tb_node_reg_buffer;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         vin  [3];
    logic         rdy  [3];
    logic         fl   [3];
    logic [W-1:0] din  [3];
    logic         upr  [3];
    logic         dv   [3];
    logic [W-1:0] dout [3];
    logic [2:0]   cnt  [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int unsigned D  = (gi == 0) ? 2 : (gi == 1) ? 4 : 3;
            localparam int unsigned CW = $clog2(D + 1);
            logic [CW-1:0] c;
            logic          u;
            logic          v;
            logic [W-1:0]  d;
            node_reg_buffer #(.WIDTH(W), .DEPTH(D)) dut (
                .clk          (clk),
                .rst_n        (rst_n),
                .data_in      (din[gi]),
                .up_valid_in  (vin[gi]),
                .up_ready_out (u),
                .data_out     (d),
                .dn_valid_out (v),
                .dn_ready_in  (rdy[gi]),
                .flush_in     (fl[gi]),
                .count_out    (c)
            );
            assign upr[gi]  = u;
            assign dv[gi]   = v;
            assign dout[gi] = d;
            assign cnt[gi]  = 3'(c);
        end
    endgenerate

    int total = 0;
    int bad   = 0;

    // Reference model of the active instance: a plain FIFO queue.
    logic [W-1:0] q[$];
    bit           mready;
    int           cur;

    function automatic int dep(input int k);
        return (k == 0) ? 2 : (k == 1) ? 4 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_check(input string tag);
        chk({tag, " count"}, 32'(cnt[cur]), q.size());
        chk({tag, " valid"}, 32'(dv[cur]), (q.size() != 0) ? 1 : 0);
        chk({tag, " data"},  32'(dout[cur]), (q.size() != 0) ? 32'(q[0]) : 0);
        chk({tag, " ready"}, 32'(upr[cur]), 32'(mready));
    endtask

    // One clock on the active instance: drive, edge, update model, check.
    task automatic cyc(input bit v, input logic [W-1:0] d, input bit r, input bit f,
                       input string tag);
        bit           push;
        bit           pop;
        logic [W-1:0] popped;
        vin[cur] = v;
        din[cur] = d;
        rdy[cur] = r;
        fl[cur]  = f;
        popped   = '0;
        push     = v && mready && !f;
        pop      = (q.size() != 0) && r;
        if (pop) popped = q[0];
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            mready = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (f) q.delete();
            else if (push) q.push_back(d);
            mready = (q.size() < dep(cur));
        end
        @(negedge clk);
        if (push || pop || f)
            $display("inst %0d %s: push=%0d din=%h pop=%0d out=%h flush=%0d count=%0d",
                     cur, tag, push, d, pop, popped, f, q.size());
        model_check(tag);
    endtask

    typedef struct {
        bit           v;
        logic [W-1:0] d;
        bit           r;
        logic [2:0]   ec;
        bit           ev;
        logic [W-1:0] ed;
        bit           er;
    } vec_t;

    vec_t tv [11];

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vin[k] = 1'b1; rdy[k] = 1'b0; fl[k] = 1'b0; din[k] = 8'h55;
        end
        q.delete();
        mready = 1'b0;
        cur = 0;

        // Reset held 3 cycles with valid asserted: nothing accepted.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset ready", 32'(upr[k]), 0);
            chk("reset valid", 32'(dv[k]), 0);
            chk("reset data",  32'(dout[k]), 0);
            chk("reset count", 32'(cnt[k]), 0);
        end
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) chk("post-release ready low", 32'(upr[k]), 0);
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("first edge ready", 32'(upr[k]), 1);
            chk("first edge count", 32'(cnt[k]), 0);
            chk("first edge valid", 32'(dv[k]), 0);
            vin[k] = 1'b0;
        end
        mready = 1'b1;

        // Streaming through DEPTH=2.
        cur = 0;
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 8'(i), 1'b1, 1'b0, "stream");
            chk("stream count<=1", (cnt[0] <= 3'd1) ? 1 : 0, 1);
        end
        repeat (2) cyc(1'b0, 8'h00, 1'b1, 1'b0, "stream drain");

        // Backpressure and simultaneous push/pop at count 3, DEPTH=4.
        cur = 1;
        tv[0]  = '{1'b1, 8'hA0, 1'b0, 3'd1, 1'b1, 8'hA0, 1'b1};
        tv[1]  = '{1'b1, 8'hA1, 1'b0, 3'd2, 1'b1, 8'hA0, 1'b1};
        tv[2]  = '{1'b1, 8'hA2, 1'b0, 3'd3, 1'b1, 8'hA0, 1'b1};
        tv[3]  = '{1'b1, 8'hA3, 1'b0, 3'd4, 1'b1, 8'hA0, 1'b0};
        tv[4]  = '{1'b1, 8'hA4, 1'b0, 3'd4, 1'b1, 8'hA0, 1'b0};
        tv[5]  = '{1'b1, 8'hA4, 1'b1, 3'd3, 1'b1, 8'hA1, 1'b1};
        tv[6]  = '{1'b1, 8'hA4, 1'b1, 3'd3, 1'b1, 8'hA2, 1'b1};
        tv[7]  = '{1'b1, 8'hA5, 1'b1, 3'd3, 1'b1, 8'hA3, 1'b1};
        tv[8]  = '{1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 8'hA4, 1'b1};
        tv[9]  = '{1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 8'hA5, 1'b1};
        tv[10] = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b1};
        for (int i = 0; i < 11; i++) begin
            cyc(tv[i].v, tv[i].d, tv[i].r, 1'b0, "bp");
            chk("bp table count", 32'(cnt[1]), 32'(tv[i].ec));
            chk("bp table valid", 32'(dv[1]), 32'(tv[i].ev));
            chk("bp table data",  32'(dout[1]), 32'(tv[i].ed));
            chk("bp table ready", 32'(upr[1]), 32'(tv[i].er));
        end

        // Flush at count 3 with concurrent push and pop.
        cyc(1'b1, 8'hB0, 1'b0, 1'b0, "fill");
        cyc(1'b1, 8'hB1, 1'b0, 1'b0, "fill");
        cyc(1'b1, 8'hB2, 1'b0, 1'b0, "fill");
        chk("pre-flush count", 32'(cnt[1]), 3);
        cyc(1'b1, 8'hBF, 1'b1, 1'b1, "flush");
        chk("flush count", 32'(cnt[1]), 0);
        chk("flush valid", 32'(dv[1]), 0);
        chk("flush data",  32'(dout[1]), 0);
        chk("flush ready", 32'(upr[1]), 1);
        cyc(1'b1, 8'hC0, 1'b0, 1'b0, "post-flush");
        chk("flushed word absent", (dout[1] == 8'hBF) ? 1 : 0, 0);
        chk("post-flush head", 32'(dout[1]), 32'h0C0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, "post-flush drain");
        vin[1] = 1'b0; rdy[1] = 1'b0; fl[1] = 1'b0;

        // Randomised traffic: odd depth first, then the other two.
        for (int s = 0; s < 3; s++) begin
            cur = (s == 0) ? 2 : s - 1;
            mready = 1'b1;
            for (int i = 0; i < 80; i++) begin
                cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 15) == 0), "rand");
            end
            repeat (6) cyc(1'b0, 8'h00, 1'b1, 1'b0, "rand drain");
            vin[cur] = 1'b0; rdy[cur] = 1'b0; fl[cur] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
